// File: rtl/aes_v3_pkg.sv
// Shared definitions for the AES column sequencer: FSM encoding, step count,
// request payload and GF(2^8) / S-box helpers used by the byte unit.
package aes_v3_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned AES_V3_COL_STEPS = 4;
  localparam int unsigned WORD_W           = 32;

  // Registered request operands held for the whole column computation.
  typedef struct packed {
    logic                   mix;
    logic [1:0]             col;
    logic [3:0][WORD_W-1:0] s;
  } col_req_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = gf_mul(x, x);
    r  = sq;
    for (int i = 0; i < 6; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
           {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] a;
    a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(a);
  endfunction

endpackage

// File: rtl/aes_v3_1.sv
// Single-byte AES round unit: rd = rs1 ^ rotl(mix(sbox(rs2.byte[bs])), 8*bs).
// DECRYPT_EN=0 removes the inverse S-box / InvMixColumns path.
module aes_v3_1
  import aes_v3_pkg::*;
#(
  parameter bit DECRYPT_EN = 1'b1
) (
  input  logic              valid,
  input  logic              dec,
  input  logic              mix,
  input  logic [WORD_W-1:0] rs1,
  input  logic [WORD_W-1:0] rs2,
  input  logic [1:0]        bs,
  output logic [WORD_W-1:0] rd
);

  logic              dec_en;
  logic [7:0]        sel_byte;
  logic [7:0]        sb;
  logic [WORD_W-1:0] col_word;
  logic [WORD_W-1:0] rot_word;

  // Byte select, substitution and the single-column (Inv)MixColumns contribution.
  always_comb begin
    dec_en   = DECRYPT_EN && dec;
    sel_byte = rs2[{bs, 3'b000} +: 8];
    sb       = dec_en ? inv_sbox(sel_byte) : sbox(sel_byte);
    if (!mix) begin
      col_word = {24'h000000, sb};
    end else if (dec_en) begin
      col_word = {gf_mul(sb, 8'h0b), gf_mul(sb, 8'h0d), gf_mul(sb, 8'h09), gf_mul(sb, 8'h0e)};
    end else begin
      col_word = {xtime(sb) ^ sb, sb, sb, xtime(sb)};
    end
    case (bs)
      2'd0:    rot_word = col_word;
      2'd1:    rot_word = {col_word[23:0], col_word[31:24]};
      2'd2:    rot_word = {col_word[15:0], col_word[31:16]};
      default: rot_word = {col_word[7:0], col_word[31:8]};
    endcase
    rd = valid ? (rs1 ^ rot_word) : '0;
  end

endmodule

// File: rtl/aes_v3_col.sv
// Column sequencer: runs aes_v3_1 four times to build one AES round column.
// Define AES_V3_COL_DECRYPT_EN to honour req_dec (inverse ShiftRows indexing).
module aes_v3_col
  import aes_v3_pkg::*;
(
  input  logic              g_clk,
  input  logic              g_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_dec,
  input  logic              req_mix,
  input  logic [1:0]        req_col,
  input  logic [WORD_W-1:0] req_s0,
  input  logic [WORD_W-1:0] req_s1,
  input  logic [WORD_W-1:0] req_s2,
  input  logic [WORD_W-1:0] req_s3,
  input  logic [WORD_W-1:0] req_rk,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_data,
  output logic              busy
);

  logic [1:0]        state_q, state_d;
  logic [1:0]        step_q, step_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  col_req_t          req_q, req_d;
  logic              dec_q, dec_d;

  logic              run;
  logic [1:0]        src_idx;
  logic              u_valid;
  logic              u_dec;
  logic              u_mix;
  logic [WORD_W-1:0] u_rs1;
  logic [WORD_W-1:0] u_rs2;
  logic [1:0]        u_bs;
  logic [WORD_W-1:0] u_rd;

`ifdef AES_V3_COL_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
  logic          req_dec_eff;
  assign req_dec_eff = req_dec;
`else
  localparam bit DEC_EN = 1'b0;
  logic          req_dec_eff;
  logic          unused_req_dec;
  assign req_dec_eff    = 1'b0;
  assign unused_req_dec = req_dec;
`endif

  // Operand mux: ShiftRows source column; operands held at zero outside RUN.
  always_comb begin
    run = (state_q == ST_RUN);
`ifdef AES_V3_COL_DECRYPT_EN
    src_idx = dec_q ? 2'(req_q.col - step_q) : 2'(req_q.col + step_q);
`else
    src_idx = 2'(req_q.col + step_q);
`endif
    u_valid = run;
    u_dec   = run & dec_q;
    u_mix   = run & req_q.mix;
    u_rs1   = run ? acc_q : '0;
    u_rs2   = run ? req_q.s[src_idx] : '0;
    u_bs    = run ? step_q : 2'd0;
  end

  aes_v3_1 #(
    .DECRYPT_EN (DEC_EN)
  ) i_aes_v3_1 (
    .valid (u_valid),
    .dec   (u_dec),
    .mix   (u_mix),
    .rs1   (u_rs1),
    .rs2   (u_rs2),
    .bs    (u_bs),
    .rd    (u_rd)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    acc_d       = acc_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    req_ready_d = req_ready_q;
    busy_d      = busy_q;
    req_d       = req_q;
    dec_d       = dec_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d.mix   = req_mix;
          req_d.col   = req_col;
          req_d.s     = {req_s3, req_s2, req_s1, req_s0};
          dec_d       = req_dec_eff;
          acc_d       = req_rk;
          step_d      = 2'd0;
          state_d     = ST_RUN;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      ST_RUN: begin
        acc_d  = u_rd;
        step_d = 2'(step_q + 2'd1);
        if (step_q == 2'(AES_V3_COL_STEPS - 1)) begin
          state_d     = ST_DONE;
          rsp_data_d  = u_rd;
          rsp_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q     <= ST_IDLE;
      step_q      <= 2'd0;
      acc_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      req_q       <= '0;
      dec_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      req_q       <= req_d;
      dec_q       <= dec_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_v3_col.sv
// Directed self-checking bench for aes_v3_col; decrypt cases follow
// AES_V3_COL_DECRYPT_EN.
module tb_aes_v3_col;

  logic        g_clk;
  logic        g_reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_dec;
  logic        req_mix;
  logic [1:0]  req_col;
  logic [31:0] req_s0, req_s1, req_s2, req_s3, req_rk;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  aes_v3_col dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dec   (req_dec),
    .req_mix   (req_mix),
    .req_col   (req_col),
    .req_s0    (req_s0),
    .req_s1    (req_s1),
    .req_s2    (req_s2),
    .req_s3    (req_s3),
    .req_rk    (req_rk),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic drive_req(input logic dec, input logic mix, input logic [1:0] col,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d,
                           input logic [31:0] rk);
    req_valid = 1'b1;
    req_dec   = dec;
    req_mix   = mix;
    req_col   = col;
    req_s0    = a;
    req_s1    = b;
    req_s2    = c;
    req_s3    = d;
    req_rk    = rk;
  endtask

  // Issue one request from IDLE with rsp_ready already high; lat counts
  // edges after the accept edge until rsp_valid is seen.
  task automatic run_col(input logic dec, input logic mix, input logic [1:0] col,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d,
                         input logic [31:0] rk,
                         output logic [31:0] data, output int lat, output bit busy_ok);
    int k;
    busy_ok = 1'b1;
    lat     = -1;
    data    = 32'hxxxxxxxx;
    drive_req(dec, mix, col, a, b, c, d, rk);
    rsp_ready = 1'b1;
    @(posedge g_clk); #1;
    req_valid = 1'b0;
    k = 0;
    while (lat < 0 && k < 20) begin
      k++;
      if (busy !== 1'b1 || req_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge g_clk); #1;
      if (rsp_valid === 1'b1) begin
        lat  = k;
        data = rsp_data;
      end
    end
    @(posedge g_clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    g_reset   = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    drive_req(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    req_valid = 1'b0;
    repeat (2) @(posedge g_clk);
    #1;
    g_reset = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 00000000", rsp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_fips;
    logic [31:0] d; int lat; bit bok;
    run_col(1'b0, 1'b1, 2'd0, 32'hbee33d19, 32'h2be2f4a0, 32'h2a8dc69a, 32'h0848f8e9,
            32'h17fefaa0, d, lat, bok);
    checks++; if (d !== 32'hf27f9ca4) begin errors++; $display("FAIL fips_data: got %h expected f27f9ca4", d); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL fips_latency: got %0d expected 4", lat); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL fips_busy_ready: got %b expected 1", bok); end
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL fips_release: got valid=%b ready=%b expected valid=0 ready=1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_zero;
    logic [31:0] d; int lat; bit bok;
    for (int c = 0; c < 4; c++) begin
      run_col(1'b0, 1'b0, 2'(c), 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, d, lat, bok);
      checks++; if (d !== 32'h63636363) begin errors++; $display("FAIL zero_final_col%0d: got %h expected 63636363", c, d); end
    end
    run_col(1'b0, 1'b1, 2'd2, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, d, lat, bok);
    checks++; if (d !== 32'h63636363) begin errors++; $display("FAIL zero_mix: got %h expected 63636363", d); end
  endtask

  // Column j holds byte value j, so each output byte names its source column.
  task automatic test_shift_rows;
    logic [31:0] d; int lat; bit bok;
    logic [31:0] exp_t [4];
    exp_t[0] = 32'h7b777c63; exp_t[1] = 32'h637b777c;
    exp_t[2] = 32'h7c637b77; exp_t[3] = 32'h777c637b;
    for (int c = 0; c < 4; c++) begin
      run_col(1'b0, 1'b0, 2'(c), 32'h00000000, 32'h01010101, 32'h02020202, 32'h03030303,
              32'h0, d, lat, bok);
      checks++; if (d !== exp_t[c]) begin errors++; $display("FAIL shift_col%0d: got %h expected %h", c, d, exp_t[c]); end
    end
  endtask

  task automatic test_decrypt;
    logic [31:0] d; int lat; bit bok;
`ifdef AES_V3_COL_DECRYPT_EN
    logic [31:0] exp_s [4];
    exp_s[0] = 32'h00000000; exp_s[1] = 32'h01010101;
    exp_s[2] = 32'h02020202; exp_s[3] = 32'h03030303;
    run_col(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, d, lat, bok);
    checks++; if (d !== 32'h52525252) begin errors++; $display("FAIL dec_zero: got %h expected 52525252", d); end
    for (int c = 0; c < 4; c++) begin
      run_col(1'b1, 1'b0, 2'(c), 32'h7b777c63, 32'h637b777c, 32'h7c637b77, 32'h777c637b,
              32'h0, d, lat, bok);
      checks++; if (d !== exp_s[c]) begin errors++; $display("FAIL dec_roundtrip_col%0d: got %h expected %h", c, d, exp_s[c]); end
    end
`else
    run_col(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, d, lat, bok);
    checks++; if (d !== 32'h63636363) begin errors++; $display("FAIL dec_disabled: got %h expected 63636363", d); end
`endif
  endtask

  task automatic test_backpressure;
    bit stable_ok; int k; logic [31:0] d;
    rsp_ready = 1'b0;
    drive_req(1'b0, 1'b0, 2'd1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(posedge g_clk); #1;
    req_valid = 1'b0;
    k = 0;
    while (rsp_valid !== 1'b1 && k < 20) begin k++; @(posedge g_clk); #1; end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout: got %b expected 1", rsp_valid); end
    stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge g_clk); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h63636363 || req_ready !== 1'b0 || busy !== 1'b1)
        stable_ok = 1'b0;
    end
    checks++; if (stable_ok !== 1'b1) begin
      errors++; $display("FAIL bp_hold: got valid=%b data=%h ready=%b expected valid=1 data=63636363 ready=0", rsp_valid, rsp_data, req_ready);
    end
    drive_req(1'b0, 1'b1, 2'd0, 32'hbee33d19, 32'h2be2f4a0, 32'h2a8dc69a, 32'h0848f8e9, 32'h17fefaa0);
    rsp_ready = 1'b1;
    @(posedge g_clk); #1;
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_transfer: got valid=%b ready=%b busy=%b expected 0 1 0", rsp_valid, req_ready, busy);
    end
    checks++; if (rsp_data !== 32'h63636363) begin errors++; $display("FAIL bp_data_retained: got %h expected 63636363", rsp_data); end
    @(posedge g_clk); #1;
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL bp_accept: got ready=%b busy=%b expected 0 1", req_ready, busy);
    end
    k = 0;
    while (rsp_valid !== 1'b1 && k < 20) begin k++; @(posedge g_clk); #1; end
    d = rsp_data;
    checks++; if (k !== 4) begin errors++; $display("FAIL bp_second_latency: got %0d expected 4", k); end
    checks++; if (d !== 32'hf27f9ca4) begin errors++; $display("FAIL bp_second_data: got %h expected f27f9ca4", d); end
    rsp_ready = 1'b1;
    @(posedge g_clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] d; int lat; bit bok;
    drive_req(1'b0, 1'b1, 2'd3, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'hffffffff);
    @(posedge g_clk); #1;
    req_valid = 1'b0;
    repeat (2) begin @(posedge g_clk); #1; end
    g_reset = 1'b1;
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL abort_rsp_data: got %h expected 00000000", rsp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_req_ready: got %b expected 1", req_ready); end
    run_col(1'b0, 1'b1, 2'd0, 32'hbee33d19, 32'h2be2f4a0, 32'h2a8dc69a, 32'h0848f8e9,
            32'h17fefaa0, d, lat, bok);
    checks++; if (d !== 32'hf27f9ca4) begin errors++; $display("FAIL abort_next_data: got %h expected f27f9ca4", d); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL abort_next_latency: got %0d expected 4", lat); end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_zero();
    test_shift_rows();
    test_decrypt();
    test_backpressure();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_v3_col.md
# aes_v3_col

Multi-cycle column sequencer that computes one full AES round column by iterating the single-byte `aes_v3_1` functional unit four times. For each of the four byte positions it feeds the unit the correct ShiftRows source word and byte select, and it accumulates the returned words into a round-key-seeded register. It sits directly upstream of `aes_v3_1`, driving its `valid/dec/mix/rs1/rs2/bs` operands and consuming its `rd`. Upstream of the sequencer sits the coprocessor/accelerator issue logic, which uses a valid/ready request–response handshake.

## Interface
Parameters:
- none; the decrypt feature is controlled by macro (see Configuration)

Ports:
- `g_clk` in 1 — clock; all state updates on rising edge
- `g_reset` in 1 — synchronous, active-high reset
- `req_valid` in 1 — request present
- `req_ready` out 1 — sequencer can accept a request (IDLE only)
- `req_dec` in 1 — 0 = encrypt column, 1 = decrypt column
- `req_mix` in 1 — 1 = apply (Inv)MixColumns (middle round), 0 = final round
- `req_col` in 2 — output column index c
- `req_s0..req_s3` in 32 each — current state columns; byte 0 is the first byte in FIPS order
- `req_rk` in 32 — round-key word for column c
- `rsp_valid` out 1 — result available
- `rsp_ready` in 1 — consumer accepts the result
- `rsp_data` out 32 — new state column c
- `busy` out 1 — high in RUN or DONE

## Operation
- Reset values: `req_ready`=1 from the first cycle after reset, `rsp_valid`=0, `rsp_data`=0, `busy`=0. FSM=IDLE, step counter=0, accumulator=0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid&&req_ready`, register `dec, mix, col, s0..s3`, load accumulator←`req_rk`, step←0, go to RUN.
- RUN, step i∈{0..3}:
  - Drive the unit with `valid`=1, `bs`=i, `rs1`=accumulator.
  - `rs2`=s[(col+i)&3] for encrypt; `rs2`=s[(col−i)&3] for decrypt. Indices are 2-bit, so wrap-around is modulo 4.
  - At the edge, accumulator←`rd`, step←step+1 (2-bit, wraps).
  - After step 3, go to DONE and copy the accumulator into `rsp_data`.
- DONE:
  - `rsp_valid`=1; `rsp_data` is held stable until accepted.
  - On `rsp_ready`, go to IDLE, `rsp_valid`←0. `rsp_data` retains its last value.
- The unit's `valid` is driven low outside RUN, and its operands are zeroed outside RUN for power gating.
- New requests are never accepted in RUN or DONE; `req_*` inputs are ignored there.
- `rsp_ready` is ignored outside DONE.
- A reset asserted in any state wins over all other events: the in-flight column is discarded and the reset values apply at the next edge.

## Timing
- Accept edge = cycle 0. Steps run in cycles 1–4. `rsp_valid` rises at the edge ending cycle 4, i.e. it is high in cycle 5.
- Minimum request-to-request spacing is 6 cycles: accept, 4 RUN cycles, 1 DONE cycle with `rsp_ready`=1, then IDLE.
- A `rsp_ready` that is already high when `rsp_valid` rises completes the transfer in that cycle.
- The combinational path per RUN cycle is mux → `aes_v3_1` → accumulator. The unit's own sbox+mix path is the critical path; no extra logic may be added after `rd`.

## Configuration
- `AES_V3_COL_DECRYPT_EN` defined: `req_dec` is honoured; decrypt selects inverse indexing and drives `dec`=1 to the unit.
- Macro undefined:
  - `req_dec` is treated as 0.
  - The inverse index path is removed.
  - The unit is instantiated with `DECRYPT_EN`=0.
  - A decrypt request then returns the encrypt result.

## Structure
- Shared package `aes_v3_pkg`: FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the constant `AES_V3_COL_STEPS`=4.
- Exactly one sub-module: `aes_v3_1`, instance `i_aes_v3_1`.
- All sequencing, operand muxing and accumulation live in this block.

## Test plan
- FIPS-197 App. B, round 1, encrypt middle round:
  - Stimulus: s0=0xbee33d19, s1=0x2be2f4a0, s2=0x2a8dc69a, s3=0x0848f8e9, rk=0x17fefaa0, col=0, mix=1.
  - Required: `rsp_data`=0xf27f9ca4, with `rsp_valid` high in cycle 5.
- All-zero state and key, encrypt, mix=0, every col 0–3 → `rsp_data`=0x63636363.
- All-zero state and key, encrypt, mix=1 → 0x63636363 (MixColumns of a uniform column is identity).
- With `AES_V3_COL_DECRYPT_EN`: all-zero state and key, dec=1, mix=0 → 0x52525252.
  - Then feed the encrypt-final output back with decrypt and the same rk and verify it round-trips, exercising the (col−i) wrap indexing.
- Backpressure:
  - Hold `rsp_ready`=0 for 10 cycles: `rsp_valid`/`rsp_data` stay stable and `req_ready`=0.
  - Then assert `rsp_ready` with `req_valid` held high: accept occurs exactly one cycle after the response transfer.
- Assert `g_reset` in RUN at step 2:
  - Next cycle `rsp_valid`=0, `rsp_data`=0, `busy`=0, `req_ready`=1.
  - A following request produces the correct result with no residue from the aborted column.
